intersection_ctrl: RTL and testbench

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_ctrl_pkg.sv | 43 ++++
 rtl/intersection_ctrl_phase_timer.sv | 30 +++
 rtl/intersection_ctrl.sv | 125 ++++++++++++
 tb/tb_intersection_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/intersection_ctrl_pkg.sv
// Shared types and default timing for the intersection controller.
// Holds the phase state enum, 8-bit phase count type and lamp decode.
package intersection_ctrl_pkg;

  typedef enum logic [2:0] {
    NS_G,
    NS_Y,
    RED_A,
    EW_G,
    EW_Y,
    RED_B
  } state_t;

  typedef logic [7:0] cnt_t;

  localparam int unsigned DEF_GREEN_T  = 60;
  localparam int unsigned DEF_YELLOW_T = 5;
  localparam int unsigned DEF_ALLRED_T = 2;
  localparam int unsigned DEF_REQ_MIN  = 10;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
  } lamps_t;

  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t l;
    l = '0;
    case (s)
      NS_G:    begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
      NS_Y:    begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
      EW_G:    begin l.ew_green  = 1'b1; l.ns_red = 1'b1; end
      EW_Y:    begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
      default: begin l.ns_red    = 1'b1; l.ew_red = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Loadable 8-bit phase down-counter; stops at 1, o_done flags the last cycle.
module phase_timer
  import intersection_ctrl_pkg::*;
#(
  parameter cnt_t RST_VAL = cnt_t'(DEF_ALLRED_T)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  cnt_t i_load_val,
  output cnt_t o_cnt,
  output logic o_done
);

  cnt_t r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt > 8'd1) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == 8'd1);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way intersection light sequencer with request-shortened greens.
// Optional EMERGENCY_EN macro adds the emerg override input.
module intersection_ctrl
  import intersection_ctrl_pkg::*;
#(
  parameter int unsigned GREEN_T  = DEF_GREEN_T,
  parameter int unsigned YELLOW_T = DEF_YELLOW_T,
  parameter int unsigned ALLRED_T = DEF_ALLRED_T,
  parameter int unsigned REQ_MIN  = DEF_REQ_MIN
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef EMERGENCY_EN
  input  logic       emerg,
`endif
  input  logic       req_ns,
  input  logic       req_ew,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [7:0] clock
);

  localparam cnt_t GREEN_C  = cnt_t'(GREEN_T);
  localparam cnt_t YELLOW_C = cnt_t'(YELLOW_T);
  localparam cnt_t ALLRED_C = cnt_t'(ALLRED_T);
  localparam cnt_t REQMIN_C = cnt_t'(REQ_MIN);

  state_t r_state, w_next;
  logic   r_pend_ns, r_pend_ew;
  lamps_t r_lamps;
  logic   w_load, w_done, w_emerg;
  cnt_t   w_load_val, w_cnt;

`ifdef EMERGENCY_EN
  assign w_emerg = emerg;
`else
  assign w_emerg = 1'b0;
`endif

  phase_timer #(
    .RST_VAL(ALLRED_C)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_cnt     (w_cnt),
    .o_done    (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RED_B;
      r_pend_ns <= 1'b0;
      r_pend_ew <= 1'b0;
      r_lamps   <= decode_lamps(RED_B);
    end else begin
      r_state <= w_next;
      r_lamps <= decode_lamps(w_next);
      if (w_next == NS_G && r_state != NS_G) r_pend_ns <= 1'b0;
      else if (req_ns && r_state != NS_G)    r_pend_ns <= 1'b1;
      if (w_next == EW_G && r_state != EW_G) r_pend_ew <= 1'b0;
      else if (req_ew && r_state != EW_G)    r_pend_ew <= 1'b1;
    end
  end

  // Emergency forces green to yellow; all-red holds at cnt==1 until released.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      NS_G: begin
        if (w_emerg || w_done) begin
          w_next = NS_Y; w_load = 1'b1; w_load_val = YELLOW_C;
        end else if ((r_pend_ew || req_ew) && w_cnt > REQMIN_C) begin
          w_load = 1'b1; w_load_val = REQMIN_C;
        end
      end
      NS_Y: begin
        if (w_done) begin
          w_next = RED_A; w_load = 1'b1; w_load_val = ALLRED_C;
        end
      end
      RED_A: begin
        if (w_done && !w_emerg) begin
          w_next = EW_G; w_load = 1'b1; w_load_val = GREEN_C;
        end
      end
      EW_G: begin
        if (w_emerg || w_done) begin
          w_next = EW_Y; w_load = 1'b1; w_load_val = YELLOW_C;
        end else if ((r_pend_ns || req_ns) && w_cnt > REQMIN_C) begin
          w_load = 1'b1; w_load_val = REQMIN_C;
        end
      end
      EW_Y: begin
        if (w_done) begin
          w_next = RED_B; w_load = 1'b1; w_load_val = ALLRED_C;
        end
      end
      RED_B: begin
        if (w_done && !w_emerg) begin
          w_next = NS_G; w_load = 1'b1; w_load_val = GREEN_C;
        end
      end
      default: begin
        w_next = RED_B; w_load = 1'b1; w_load_val = ALLRED_C;
      end
    endcase
  end

  assign ns_red    = r_lamps.ns_red;
  assign ns_yellow = r_lamps.ns_yellow;
  assign ns_green  = r_lamps.ns_green;
  assign ew_red    = r_lamps.ew_red;
  assign ew_yellow = r_lamps.ew_yellow;
  assign ew_green  = r_lamps.ew_green;
  assign clock     = w_cnt;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl at default timing (60/5/2, REQ_MIN 10).
module tb_intersection_ctrl;

  localparam logic [5:0] L_RED = 6'b100_100;
  localparam logic [5:0] L_NSG = 6'b001_100;
  localparam logic [5:0] L_NSY = 6'b010_100;
  localparam logic [5:0] L_EWG = 6'b100_001;
  localparam logic [5:0] L_EWY = 6'b100_010;

  typedef struct {
    logic        rq_ns;
    logic        rq_ew;
    int unsigned n;
    logic [5:0]  lamps;
    logic [7:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_ns = 1'b0;
  logic req_ew = 1'b0;
  logic emerg = 1'b0;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [7:0] clock;
  logic [5:0] w_lamps;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  intersection_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef EMERGENCY_EN
    .emerg    (emerg),
`endif
    .req_ns   (req_ns),
    .req_ew   (req_ew),
    .ns_red   (ns_red),
    .ns_yellow(ns_yellow),
    .ns_green (ns_green),
    .ew_red   (ew_red),
    .ew_yellow(ew_yellow),
    .ew_green (ew_green),
    .clock    (clock)
  );

  assign w_lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] exp_l, input logic [7:0] exp_c);
    n_checks++;
    if (w_lamps !== exp_l) begin
      n_errors++;
      $display("FAIL %s lamps: got %b expected %b", name, w_lamps, exp_l);
    end
    n_checks++;
    if (clock !== exp_c) begin
      n_errors++;
      $display("FAIL %s clock: got %0d expected %0d", name, clock, exp_c);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic b, input int unsigned n,
                              input logic [5:0] l, input logic [7:0] c);
    vec_t v;
    v.rq_ns = a; v.rq_ew = b; v.n = n; v.lamps = l; v.cnt = c;
    return v;
  endfunction

  task automatic reset_release();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Nominal cycle, request shortening, ignored/latched requests.
    vecs.push_back(mk(0, 0, 0,  L_RED, 8'd2));
    vecs.push_back(mk(0, 0, 1,  L_RED, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_NSG, 8'd60));
    vecs.push_back(mk(0, 0, 1,  L_NSG, 8'd59));
    vecs.push_back(mk(0, 0, 58, L_NSG, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_NSY, 8'd5));
    vecs.push_back(mk(0, 0, 4,  L_NSY, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_RED, 8'd2));
    vecs.push_back(mk(0, 0, 1,  L_RED, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_EWG, 8'd60));
    vecs.push_back(mk(0, 0, 20, L_EWG, 8'd40));
    vecs.push_back(mk(1, 0, 1,  L_EWG, 8'd10));
    vecs.push_back(mk(0, 0, 9,  L_EWG, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_EWY, 8'd5));
    vecs.push_back(mk(0, 0, 5,  L_RED, 8'd2));
    vecs.push_back(mk(0, 0, 1,  L_RED, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_NSG, 8'd60));
    vecs.push_back(mk(0, 0, 52, L_NSG, 8'd8));
    vecs.push_back(mk(0, 1, 1,  L_NSG, 8'd7));
    vecs.push_back(mk(0, 1, 6,  L_NSG, 8'd1));
    vecs.push_back(mk(0, 1, 1,  L_NSY, 8'd5));
    vecs.push_back(mk(0, 1, 4,  L_NSY, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_RED, 8'd2));
    vecs.push_back(mk(0, 0, 2,  L_EWG, 8'd60));
    vecs.push_back(mk(0, 0, 1,  L_EWG, 8'd59));
    vecs.push_back(mk(0, 1, 1,  L_EWG, 8'd58));
    vecs.push_back(mk(0, 0, 57, L_EWG, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_EWY, 8'd5));
    vecs.push_back(mk(0, 0, 5,  L_RED, 8'd2));
    vecs.push_back(mk(0, 1, 1,  L_RED, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_NSG, 8'd60));
    vecs.push_back(mk(0, 0, 1,  L_NSG, 8'd10));
    vecs.push_back(mk(0, 0, 9,  L_NSG, 8'd1));
    vecs.push_back(mk(0, 0, 1,  L_NSY, 8'd5));

    #12;
    check("in_reset", L_RED, 8'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req_ns = vecs[i].rq_ns;
      req_ew = vecs[i].rq_ew;
      step(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].lamps, vecs[i].cnt);
    end
    req_ns = 1'b0;
    req_ew = 1'b0;

    // Asynchronous reset in the middle of NS green.
    reset_release();
    step(32);
    check("pre_abort", L_NSG, 8'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_abort", L_RED, 8'd2);
    step(1);
    check("abort_hold", L_RED, 8'd2);
    rst_n = 1'b1;
    step(1);
    check("rel_red", L_RED, 8'd1);
    step(1);
    check("rel_nsg", L_NSG, 8'd60);

`ifdef EMERGENCY_EN
    reset_release();
    step(79);
    check("em_pre", L_EWG, 8'd50);
    emerg = 1'b1;
    step(1);
    check("em_yel", L_EWY, 8'd5);
    step(4);
    check("em_yel_end", L_EWY, 8'd1);
    step(1);
    check("em_red", L_RED, 8'd2);
    step(11);
    check("em_hold", L_RED, 8'd1);
    emerg = 1'b0;
    step(1);
    check("em_resume", L_NSG, 8'd60);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
